data_access_mc: RTL and testbench
=================================

Name: data_access_mc

Overview:
Multi-cycle MEM-stage data access unit for the MIPS pipeline. It replaces the single-cycle, whole-word-write access path with a word-organised internal RAM that has true per-byte lane enables, a programmable wait-state count, and a stall output to the hazard/pipeline control. It executes lb/lh/lw/lbu/lhu/sb/sh/sw, selected by the instruction opcode.

Parameters:
B, 32, data/address width; the opcode decode assumes 4 byte lanes; only 32 is supported.
ADDR_W, 10, word-index bits; RAM depth = 2**ADDR_W words.
WAIT, 1, extra wait-state cycles per access; legal range 0..15.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  MEM stage holds a valid load/store this cycle
opcode  in  6  instruction opcode; [1:0] size (00 byte, 01 half, 11 word, 10 treated as word); [2] unsigned load
mem_read  in  1  load request qualifier
mem_write  in  1  store request qualifier
addr_in  in  B  byte address
write_data  in  B  store data, right-justified
busy  out  1  stall request to pipeline
data_out  out  B  registered load result, extended
data_valid  out  1  one-cycle access-complete pulse
misalign  out  1  misaligned-access flag; see Optional Feature

Behaviour:
- Reset values: state=IDLE, wait counter=0, data_out=0, data_valid=0, misalign=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE: when req & (mem_read|mem_write), latch opcode, addr_in, write_data and the rd/wr flags. Load counter=WAIT. Go to WAIT if WAIT>0, else ACCESS. Otherwise stay in IDLE.
- WAIT: decrement counter each cycle; go to ACCESS when counter reaches 1 (counter==1 → ACCESS).
- ACCESS: perform the RAM operation at this cycle's rising edge, then go to DONE.
- DONE: data_valid=1 for exactly this cycle; data_out already updated; req is ignored; next state is IDLE.
- busy (combinational) is high in WAIT and ACCESS, and in IDLE while req & (mem_read|mem_write). It is low in DONE.
- Total stall: WAIT+2 cycles. The request cycle plus DONE gives WAIT+3 cycles from request to pipeline advance.
- Word index = addr[ADDR_W+1:2]; upper address bits are ignored (aliasing/wrap-around).
- Byte lane = addr[1:0], little-endian; lane 0 = bits [7:0].
- Store byte enables:
  - sb: one lane, at addr[1:0].
  - sh: two lanes, at addr[1]*2.
  - sw: all four lanes.
- Store data: sb replicates write_data[7:0] to all lanes; sh replicates [15:0]; sw passes through. Only enabled lanes are written.
- Loads: the addressed byte/half is shifted to bit 0, then sign-extended (opcode[2]=0) or zero-extended (opcode[2]=1). Word loads are unmodified.
- data_out updates only on completed loads; stores leave it unchanged.
- mem_read & mem_write both set: the store is performed; data_out is unchanged.
- Inputs changing during WAIT/ACCESS have no effect (latched copy is used).
- Reset asserted mid-operation: FSM returns immediately to IDLE and the pending access is dropped. If reset is asserted before the ACCESS edge, no RAM write occurs.

Optional Feature:
Macro DATA_ACCESS_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned. The FSM still walks WAIT/ACCESS/DONE, but no RAM write occurs and data_out is unchanged. misalign pulses together with data_valid in DONE.
- Undefined: misalign is tied 0. Low address bits are forced aligned: half uses addr[1] only; word ignores addr[1:0]. The access proceeds normally.

Test Plan:
1. WAIT=1. sw addr 0x10 data 0xA1B2C3D4, then lw 0x10 → busy high 3 cycles per access; data_valid pulse in the 4th cycle; data_out=0xA1B2C3D4.
2. After test 1, sb addr 0x12 data 0x000000EE, then lw 0x10 → 0xA1EEC3D4. Then lb 0x12 → 0xFFFFFFEE; lbu 0x12 → 0x000000EE.
3. sh addr 0x16 data 0x8001 onto word 0x14 = 0x00000000, then lh 0x16 → 0xFFFF8001; lhu 0x16 → 0x00008001; lw 0x14 → 0x80010000.
4. WAIT=0, back-to-back lw requests held on req → busy high 2 cycles, DONE ignores req, next access starts in following IDLE; no duplicate access.
5. With macro: lw addr 0x11 → misalign=1 with data_valid, data_out unchanged, word 0x10 unchanged. Without macro: same access returns word 0x10, misalign=0.
6. Assert rst during WAIT of sw 0x20 data 0x12345678 → outputs 0, busy low after reset; subsequent lw 0x20 returns prior contents (not 0x12345678).

Source files
------------

// File: rtl/data_access_mc.sv
// data_access_mc: multi-cycle MEM-stage data access unit.
// Word-organised RAM with per-byte lane enables, WAIT programmable wait
// states and a busy stall output. Executes lb/lh/lw/lbu/lhu/sb/sh/sw.
// Optional: define DATA_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no RAM write, no data_out update, misalign pulse in DONE);
// otherwise low address bits are forced aligned and misalign is tied 0.
module data_access_mc #(
    parameter int B      = 32,
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [5:0]    opcode,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [B-1:0]  addr_in,
    input  logic [B-1:0]  write_data,
    output logic          busy,
    output logic [B-1:0]  data_out,
    output logic          data_valid,
    output logic          misalign
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;

    // Request copy captured in IDLE; later input changes are ignored
    logic [2:0]          op_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [B-1:0]        wdata_q;
    logic                rd_q;
    logic                wr_q;

    logic [B-1:0]        dout_q;
    logic [B-1:0]        mem [DEPTH];

    logic                start;
    logic [1:0]          lane;
    logic [ADDR_W-1:0]   widx;
    logic                is_half;
    logic                is_word;
    logic                mis;
    logic [3:0]          be;
    logic [B-1:0]        wdata_rep;
    logic [B-1:0]        rd_word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [B-1:0]        load_ext;
    logic                do_access;
    logic                do_write;
    logic                do_load;

    // Opcode bits above the size/sign field and address bits above the
    // word index play no part in the access (upper addresses alias).
    logic                unused_in;
    assign unused_in = ^{opcode[5:3], addr_in[B-1:ADDR_W+2]};

    assign start   = req & (mem_read | mem_write);
    assign lane    = addr_q[1:0];
    assign widx    = addr_q[ADDR_W+1:2];
    assign is_half = (op_q[1:0] == 2'b01);
    assign is_word = op_q[1];   // 10 and 11 both treated as word

`ifdef DATA_ACCESS_MISALIGN_TRAP_EN
    assign mis = (is_half & lane[0]) | (is_word & (lane != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Lane decode below already ignores lane[0] for halves and both bits for
    // words, which is exactly the forced-alignment behaviour; with the trap
    // enabled those cases never reach the RAM because mis blocks them.

    // Byte-lane enables for the store size and address
    always_comb begin
        be = '0;
        if (is_word) begin
            be = '1;
        end else if (is_half) begin
            be = lane[1] ? 4'b1100 : 4'b0011;
        end else begin
            be = 4'b0001 << lane;
        end
    end

    // Store data replicated across lanes so any enabled lane sees its bytes
    always_comb begin
        wdata_rep = wdata_q;
        if (is_word) begin
            wdata_rep = wdata_q;
        end else if (is_half) begin
            wdata_rep = {2{wdata_q[15:0]}};
        end else begin
            wdata_rep = {4{wdata_q[7:0]}};
        end
    end

    assign rd_word  = mem[widx];
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    // Load alignment to bit 0 and sign/zero extension
    always_comb begin
        load_ext = rd_word;
        if (is_word) begin
            load_ext = rd_word;
        end else if (is_half) begin
            load_ext = {{16{~op_q[2] & half_sel[15]}}, half_sel};
        end else begin
            load_ext = {{24{~op_q[2] & byte_sel[7]}}, byte_sel};
        end
    end

    assign do_access = (state_q == S_ACCESS) & ~mis;
    assign do_write  = do_access & wr_q;
    assign do_load   = do_access & rd_q & ~wr_q;

    // State and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and wait-state countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = WAIT_CNT;
                    if (WAIT_CNT != 4'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture the request in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            op_q    <= opcode[2:0];
            addr_q  <= addr_in[ADDR_W+1:0];
            wdata_q <= write_data;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
        end
    end

    // RAM lane writes on the ACCESS edge; contents survive reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // Load result register, updated only by completed loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else if (do_load) begin
            dout_q <= load_ext;
        end
    end

    assign busy       = (state_q == S_WAIT) | (state_q == S_ACCESS) |
                        ((state_q == S_IDLE) & start);
    assign data_out   = dout_q;
    assign data_valid = (state_q == S_DONE);
    assign misalign   = (state_q == S_DONE) & mis;

endmodule

// File: tb/tb_data_access_mc.sv
// Bench for data_access_mc: two instances (WAIT=1 and WAIT=0) share the
// stimulus; a byte-level model predicts busy/data_valid/data_out/misalign
// every cycle, and literal values pin the model at key points.
module tb_data_access_mc;

    localparam int ADDR_W = 10;
    localparam int NB     = 4 << ADDR_W;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr_in = '0;
    logic [31:0] write_data = '0;

    logic        busy_w  [2];
    logic [31:0] dout_w  [2];
    logic        valid_w [2];
    logic        mis_w   [2];

    always #5 clk = ~clk;

    data_access_mc #(.B(32), .ADDR_W(ADDR_W), .WAIT(1)) u_wait1 (
        .clk(clk), .rst(rst), .req(req), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write),
        .addr_in(addr_in), .write_data(write_data),
        .busy(busy_w[0]), .data_out(dout_w[0]),
        .data_valid(valid_w[0]), .misalign(mis_w[0])
    );

    data_access_mc #(.B(32), .ADDR_W(ADDR_W), .WAIT(0)) u_wait0 (
        .clk(clk), .rst(rst), .req(req), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write),
        .addr_in(addr_in), .write_data(write_data),
        .busy(busy_w[1]), .data_out(dout_w[1]),
        .data_valid(valid_w[1]), .misalign(mis_w[1])
    );

    int          waitv [2] = '{1, 0};

    // Model state per instance
    logic [7:0]  m_mem  [2][NB];
    int          m_left [2];
    bit          m_done [2];
    logic [31:0] m_dout [2];
    bit          m_mis  [2];
    logic [5:0]  t_op   [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wd   [2];
    bit          t_rd   [2];
    bit          t_wr   [2];
    int          n_valid[2];
    int          n_misp [2];

    int          n_pass = 0;
    int          n_chk  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    // Perform the latched transaction on the byte-array model
    function automatic void model_apply(int i);
        int          nb;
        int          a;
        bit          mis;
        logic [31:0] v;
        nb  = (t_op[i][1:0] == 2'b00) ? 1 : (t_op[i][1:0] == 2'b01) ? 2 : 4;
        a   = int'(t_addr[i][ADDR_W+1:0]);
        mis = 1'b0;
`ifdef DATA_ACCESS_MISALIGN_TRAP_EN
        mis = (a % nb) != 0;
`else
        a = a - (a % nb);
`endif
        m_mis[i] = mis;
        if (!mis) begin
            if (t_wr[i]) begin
                for (int k = 0; k < nb; k++) m_mem[i][a+k] = t_wd[i][8*k +: 8];
            end else if (t_rd[i]) begin
                v = '0;
                for (int k = 0; k < nb; k++) v = v | (32'(m_mem[i][a+k]) << (8*k));
                if (!t_op[i][2] && nb < 4 && v[8*nb-1])
                    v = v | ~((32'd1 << (8*nb)) - 32'd1);
                m_dout[i] = v;
            end
        end
    endfunction

    function automatic bit idle(int i);
        return (m_left[i] == 0) && !m_done[i];
    endfunction

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        bit start;
        for (int i = 0; i < 2; i++) begin
            if (valid_w[i]) n_valid[i]++;
            if (mis_w[i])   n_misp[i]++;
            if (rst) begin
                m_left[i] = 0;
                m_done[i] = 1'b0;
                m_dout[i] = '0;
                m_mis[i]  = 1'b0;
                chk($sformatf("w%0d_rst_busy", waitv[i]),  32'(busy_w[i]),  32'd0);
                chk($sformatf("w%0d_rst_valid", waitv[i]), 32'(valid_w[i]), 32'd0);
                chk($sformatf("w%0d_rst_mis", waitv[i]),   32'(mis_w[i]),   32'd0);
                chk($sformatf("w%0d_rst_dout", waitv[i]),  dout_w[i],       32'd0);
            end else begin
                chk($sformatf("w%0d_data_out", waitv[i]), dout_w[i], m_dout[i]);
                chk($sformatf("w%0d_misalign", waitv[i]), 32'(mis_w[i]),
                    32'(m_done[i] ? m_mis[i] : 1'b0));
                if (m_done[i]) begin
                    chk($sformatf("w%0d_busy_done", waitv[i]),  32'(busy_w[i]),  32'd0);
                    chk($sformatf("w%0d_valid_done", waitv[i]), 32'(valid_w[i]), 32'd1);
                    m_done[i] = 1'b0;
                end else if (m_left[i] > 0) begin
                    chk($sformatf("w%0d_busy_stall", waitv[i]), 32'(busy_w[i]),  32'd1);
                    chk($sformatf("w%0d_valid_stall", waitv[i]), 32'(valid_w[i]), 32'd0);
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        model_apply(i);
                        m_done[i] = 1'b1;
                    end
                end else begin
                    start = req & (mem_read | mem_write);
                    chk($sformatf("w%0d_busy_idle", waitv[i]),  32'(busy_w[i]),  32'(start));
                    chk($sformatf("w%0d_valid_idle", waitv[i]), 32'(valid_w[i]), 32'd0);
                    if (start) begin
                        t_op[i]   = opcode;
                        t_addr[i] = addr_in;
                        t_wd[i]   = write_data;
                        t_rd[i]   = mem_read;
                        t_wr[i]   = mem_write;
                        m_left[i] = waitv[i] + 1;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(idle(0) && idle(1)) && n < 60);
        if (!(idle(0) && idle(1))) begin
            n_chk++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    // One request cycle, then scrambled inputs to show they are ignored
    task automatic access(logic [5:0] op, logic [31:0] a, logic [31:0] wd,
                          bit rd, bit wr);
        #1;
        opcode = op; addr_in = a; write_data = wd;
        mem_read = rd; mem_write = wr; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        opcode = ~op; addr_in = ~a; write_data = ~wd;
        wait_idle();
    endtask

    task automatic lit(string nm, logic [31:0] e);
        chk({nm, "_w1"}, dout_w[0], e);
        chk({nm, "_w0"}, dout_w[1], e);
        chk({nm, "_model"}, m_dout[0], e);
    endtask

    initial begin
        int v0, v1, p0, p1;
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_done[i] = 1'b0; m_dout[i] = '0; m_mis[i] = 1'b0;
            n_valid[i] = 0; n_misp[i] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        // Word store/load
        access(SW, 32'h10, 32'hA1B2C3D4, 1'b0, 1'b1);
        access(LW, 32'h10, 32'h0, 1'b1, 1'b0);
        lit("lw_10", 32'hA1B2C3D4);

        // Byte store into lane 2, byte loads signed/unsigned
        access(SB, 32'h12, 32'h000000EE, 1'b0, 1'b1);
        access(LW, 32'h10, 32'h0, 1'b1, 1'b0);
        lit("lw_10_after_sb", 32'hA1EEC3D4);
        access(LB, 32'h12, 32'h0, 1'b1, 1'b0);
        lit("lb_12", 32'hFFFFFFEE);
        access(LBU, 32'h12, 32'h0, 1'b1, 1'b0);
        lit("lbu_12", 32'h000000EE);

        // Half store into upper half, half loads
        access(SW, 32'h14, 32'h00000000, 1'b0, 1'b1);
        access(SH, 32'h16, 32'h00008001, 1'b0, 1'b1);
        access(LH, 32'h16, 32'h0, 1'b1, 1'b0);
        lit("lh_16", 32'hFFFF8001);
        access(LHU, 32'h16, 32'h0, 1'b1, 1'b0);
        lit("lhu_16", 32'h00008001);
        access(LW, 32'h14, 32'h0, 1'b1, 1'b0);
        lit("lw_14", 32'h80010000);

        // Read and write both set: store wins, data_out untouched
        access(SW, 32'h18, 32'h55AA55AA, 1'b1, 1'b1);
        lit("rw_both_dout", 32'h80010000);
        access(LW, 32'h18, 32'h0, 1'b1, 1'b0);
        lit("lw_18", 32'h55AA55AA);

        // Upper address bits alias onto the same word
        access(LW, 32'h00001010, 32'h0, 1'b1, 1'b0);
        lit("lw_alias", 32'hA1EEC3D4);

        // Misaligned word load and half store
        p0 = n_misp[0]; p1 = n_misp[1];
        access(LW, 32'h11, 32'h0, 1'b1, 1'b0);
`ifdef DATA_ACCESS_MISALIGN_TRAP_EN
        lit("lw_11_trap", 32'hA1EEC3D4);
        chk("mis_pulse_w1", 32'(n_misp[0] - p0), 32'd1);
        chk("mis_pulse_w0", 32'(n_misp[1] - p1), 32'd1);
        access(SH, 32'h11, 32'h0000FFFF, 1'b0, 1'b1);
        access(LW, 32'h10, 32'h0, 1'b1, 1'b0);
        lit("lw_10_after_trap", 32'hA1EEC3D4);
`else
        lit("lw_11_forced", 32'hA1EEC3D4);
        chk("mis_pulse_w1", 32'(n_misp[0] - p0), 32'd0);
        chk("mis_pulse_w0", 32'(n_misp[1] - p1), 32'd0);
        access(SH, 32'h11, 32'h0000FFFF, 1'b0, 1'b1);
        access(LW, 32'h10, 32'h0, 1'b1, 1'b0);
        lit("lw_10_after_sh11", 32'hA1EEFFFF);
`endif

        // Request held for 9 cycles: DONE ignores req, no duplicates
        v0 = n_valid[0]; v1 = n_valid[1];
        #1;
        opcode = LW; addr_in = 32'h18; write_data = '0;
        mem_read = 1'b1; mem_write = 1'b0; req = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        req = 1'b0; mem_read = 1'b0;
        wait_idle();
        chk("held_count_w1", 32'(n_valid[0] - v0), 32'd3);
        chk("held_count_w0", 32'(n_valid[1] - v1), 32'd3);
        lit("held_dout", 32'h55AA55AA);

        // Reset during the stall drops the pending store
        access(SW, 32'h20, 32'hCAFEF00D, 1'b0, 1'b1);
        #1;
        opcode = SW; addr_in = 32'h20; write_data = 32'h12345678;
        mem_read = 1'b0; mem_write = 1'b1; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; mem_write = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();
        lit("after_rst_dout", 32'h00000000);
        access(LW, 32'h20, 32'h0, 1'b1, 1'b0);
        lit("lw_20_after_rst", 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
